// File: rtl/rf_scoreboard.sv
// rf_scoreboard
//   Parametrised register file with a pending-write scoreboard, used between
//   decode and writeback. Decode marks a destination pending at issue and
//   writeback clears it. Hazard logic reads the per-operand pending flags and
//   the outstanding-write count straight from this block.
//
// Parameters
//   DATA_W    register width in bits
//   ADDR_W    address width; the file holds 2**ADDR_W entries
//   ZERO_REG  1: entry 0 always reads 0, ignores writes, is never pending
//
// Ports
//   clk            rising-edge clock for all state
//   rst            synchronous active-high reset: clears data, pending bits, count
//   RegWrite       writeback enable
//   RD_Address     writeback destination
//   RDdata         writeback data (also bypassed to the read ports)
//   Issue_Valid    decode issues an instruction that writes Issue_Address
//   Issue_Address  destination to mark pending
//   RS_Address     read port A address
//   RT_Address     read port B address
//   RSdata/RTdata  combinational read data
//   RS_Pending     port A register has an outstanding write
//   RT_Pending     port B register has an outstanding write
//   Pending_Count  registered number of set pending bits
module rf_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] RD_Address,
  input  logic [DATA_W-1:0] RDdata,
  input  logic              Issue_Valid,
  input  logic [ADDR_W-1:0] Issue_Address,
  input  logic [ADDR_W-1:0] RS_Address,
  input  logic [ADDR_W-1:0] RT_Address,
  output logic [DATA_W-1:0] RSdata,
  output logic [DATA_W-1:0] RTdata,
  output logic              RS_Pending,
  output logic              RT_Pending,
  output logic [ADDR_W:0]   Pending_Count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic we_ok, iss_ok;
  logic set_evt, clr_evt;

  // Entry 0 is read-only (and never pending) when the zero register is enabled.
  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return !(ZERO_REG && (a == '0));
  endfunction

  assign we_ok  = RegWrite    && writable(RD_Address);
  assign iss_ok = Issue_Valid && writable(Issue_Address);

  // Next-state of the scoreboard. The issue mark is applied after the
  // writeback clear so that a same-address issue wins: the newer producer is
  // still outstanding.
  always_comb begin
    pend_d = pend_q;
    if (we_ok)  pend_d[RD_Address]    = 1'b0;
    if (iss_ok) pend_d[Issue_Address] = 1'b1;

    // The count tracks only real bit transitions: re-issuing a pending
    // register or writing a non-pending one leaves it unchanged.
    set_evt = iss_ok && !pend_q[Issue_Address];
    clr_evt = we_ok && pend_q[RD_Address] &&
              !(iss_ok && (Issue_Address == RD_Address));
    count_d = count_q + CNT_W'(set_evt) - CNT_W'(clr_evt);
  end

  // NOTE: the data array is cleared by reset because reset-to-zero register
  // contents are architecturally visible here; this forces it into flops
  // rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      pend_q  <= '0;
      count_q <= '0;
    end else begin
      if (we_ok) data_q[RD_Address] <= RDdata;
      pend_q  <= pend_d;
      count_q <= count_d;
    end
  end

  // Read ports: zero register first, then write-through bypass, then storage.
  // The bypass is purely combinational, so it also applies during reset.
  assign RSdata = !writable(RS_Address)                     ? '0     :
                  (RegWrite && (RD_Address == RS_Address))  ? RDdata :
                                                              data_q[RS_Address];
  assign RTdata = !writable(RT_Address)                     ? '0     :
                  (RegWrite && (RD_Address == RT_Address))  ? RDdata :
                                                              data_q[RT_Address];

  // A pending flag is hidden while the register is being written back this
  // cycle, unless the same register is also being re-issued.
  assign RS_Pending = writable(RS_Address) && pend_q[RS_Address] &&
                      !(RegWrite && (RD_Address == RS_Address) &&
                        !(Issue_Valid && (Issue_Address == RS_Address)));
  assign RT_Pending = writable(RT_Address) && pend_q[RT_Address] &&
                      !(RegWrite && (RD_Address == RT_Address) &&
                        !(Issue_Valid && (Issue_Address == RT_Address)));

  assign Pending_Count = count_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard
//   Self-checking bench for rf_scoreboard (DATA_W=32, ADDR_W=5, ZERO_REG=1).
//   Directed scenarios followed by randomized traffic checked against a
//   behavioural model: an array of register values and an array of pending
//   flags, with the expected count obtained by counting set flags.
module tb_rf_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 2 ** AW;

  logic          clk;
  logic          rst;
  logic          RegWrite;
  logic [AW-1:0] RD_Address;
  logic [DW-1:0] RDdata;
  logic          Issue_Valid;
  logic [AW-1:0] Issue_Address;
  logic [AW-1:0] RS_Address;
  logic [AW-1:0] RT_Address;
  logic [DW-1:0] RSdata;
  logic [DW-1:0] RTdata;
  logic          RS_Pending;
  logic          RT_Pending;
  logic [AW:0]   Pending_Count;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state.
  logic [DW-1:0] m_data [N];
  bit            m_pend [N];

  rf_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .RegWrite      (RegWrite),
    .RD_Address    (RD_Address),
    .RDdata        (RDdata),
    .Issue_Valid   (Issue_Valid),
    .Issue_Address (Issue_Address),
    .RS_Address    (RS_Address),
    .RT_Address    (RT_Address),
    .RSdata        (RSdata),
    .RTdata        (RTdata),
    .RS_Pending    (RS_Pending),
    .RT_Pending    (RT_Pending),
    .Pending_Count (Pending_Count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic int exp_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_pend[i]) c++;
    return c;
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (RegWrite && RD_Address == a) return RDdata;
    return m_data[a];
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (RegWrite && RD_Address == a && !(Issue_Valid && Issue_Address == a)) return 1'b0;
    return m_pend[a];
  endfunction

  // Apply the architectural effect of one clock edge to the model.
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_data[i] = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (RegWrite && RD_Address != 0) begin
        m_data[RD_Address] = RDdata;
        m_pend[RD_Address] = 1'b0;
      end
      if (Issue_Valid && Issue_Address != 0) m_pend[Issue_Address] = 1'b1;
    end
  endtask

  // One clock: model follows the edge, inputs may change 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; RegWrite = 1'b0; Issue_Valid = 1'b0;
    RD_Address = '0; RDdata = '0; Issue_Address = '0;
  endtask

  task automatic cmp_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    // Used only for formatting-free reporting of 32-bit mismatches.
    $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    RS_Address = 5'd0; RT_Address = 5'd7;
    #1;
    n_cmp++; if (RSdata !== 32'd0) begin n_err++; cmp_d("reset_rs0", RSdata, 32'd0); end
    n_cmp++; if (RTdata !== 32'd0) begin n_err++; cmp_d("reset_rt7", RTdata, 32'd0); end
    n_cmp++; if ({RS_Pending, RT_Pending} !== 2'b00) begin n_err++;
      $display("FAIL reset_pend: got %b%b expected 00", RS_Pending, RT_Pending); end
    RS_Address = 5'd31;
    #1;
    n_cmp++; if (RSdata !== 32'd0) begin n_err++; cmp_d("reset_rs31", RSdata, 32'd0); end
    n_cmp++; if (Pending_Count !== 6'd0) begin n_err++;
      $display("FAIL reset_count: got %0d expected 0", Pending_Count); end
  endtask

  task automatic test_bypass();
    idle();
    RegWrite = 1'b1; RD_Address = 5'd5; RDdata = 32'h1234; RS_Address = 5'd5;
    #1;
    n_cmp++; if (RSdata !== 32'h1234) begin n_err++; cmp_d("bypass_same_cycle", RSdata, 32'h1234); end
    tick();
    RegWrite = 1'b0; RDdata = 32'hDEAD;
    #1;
    n_cmp++; if (RSdata !== 32'h1234) begin n_err++; cmp_d("bypass_stored", RSdata, 32'h1234); end
  endtask

  task automatic test_zero_reg();
    idle();
    RegWrite = 1'b1; RD_Address = 5'd0; RDdata = 32'hFFFF;
    Issue_Valid = 1'b1; Issue_Address = 5'd0; RS_Address = 5'd0;
    #1;
    n_cmp++; if (RSdata !== 32'd0) begin n_err++; cmp_d("zero_bypass", RSdata, 32'd0); end
    n_cmp++; if (RS_Pending !== 1'b0) begin n_err++;
      $display("FAIL zero_pend_now: got %b expected 0", RS_Pending); end
    tick();
    idle();
    #1;
    n_cmp++; if (RSdata !== 32'd0) begin n_err++; cmp_d("zero_stored", RSdata, 32'd0); end
    n_cmp++; if (RS_Pending !== 1'b0) begin n_err++;
      $display("FAIL zero_pend_next: got %b expected 0", RS_Pending); end
    n_cmp++; if (Pending_Count !== 6'd0) begin n_err++;
      $display("FAIL zero_count: got %0d expected 0", Pending_Count); end
  endtask

  task automatic test_issue_sequence();
    logic [AW:0] exp_seq [3] = '{6'd1, 6'd2, 6'd2};
    logic [AW-1:0] adr_seq [3] = '{5'd3, 5'd9, 5'd3};
    for (int k = 0; k < 3; k++) begin
      idle();
      Issue_Valid = 1'b1; Issue_Address = adr_seq[k];
      tick();
      idle();
      #1;
      n_cmp++; if (Pending_Count !== exp_seq[k]) begin n_err++;
        $display("FAIL issue_seq_%0d: got %0d expected %0d", k, Pending_Count, exp_seq[k]); end
    end
    RegWrite = 1'b1; RD_Address = 5'd9; RDdata = 32'h9999;
    RT_Address = 5'd9; RS_Address = 5'd3;
    #1;
    n_cmp++; if (RT_Pending !== 1'b0) begin n_err++;
      $display("FAIL wb_hides_pend: got %b expected 0", RT_Pending); end
    n_cmp++; if (RS_Pending !== 1'b1) begin n_err++;
      $display("FAIL other_still_pend: got %b expected 1", RS_Pending); end
    tick();
    idle();
    #1;
    n_cmp++; if (Pending_Count !== 6'd1) begin n_err++;
      $display("FAIL wb_count: got %0d expected 1", Pending_Count); end
    n_cmp++; if (RTdata !== 32'h9999) begin n_err++; cmp_d("wb_data", RTdata, 32'h9999); end
  endtask

  task automatic test_issue_write_same();
    idle();
    Issue_Valid = 1'b1; Issue_Address = 5'd4;
    RegWrite = 1'b1; RD_Address = 5'd4; RDdata = 32'hABCD;
    tick();
    idle();
    RS_Address = 5'd4;
    #1;
    n_cmp++; if (RS_Pending !== 1'b1) begin n_err++;
      $display("FAIL same_pend: got %b expected 1", RS_Pending); end
    n_cmp++; if (RSdata !== 32'hABCD) begin n_err++; cmp_d("same_data", RSdata, 32'hABCD); end
    n_cmp++; if (Pending_Count !== 6'd2) begin n_err++;
      $display("FAIL same_count: got %0d expected 2", Pending_Count); end
  endtask

  task automatic test_diff_then_reset();
    idle();
    Issue_Valid = 1'b1; Issue_Address = 5'd2;
    tick();
    idle();
    Issue_Valid = 1'b1; Issue_Address = 5'd6;
    RegWrite = 1'b1; RD_Address = 5'd2; RDdata = 32'h55;
    tick();
    idle();
    RS_Address = 5'd2; RT_Address = 5'd6;
    #1;
    n_cmp++; if (Pending_Count !== 6'd3) begin n_err++;
      $display("FAIL diff_count: got %0d expected 3", Pending_Count); end
    n_cmp++; if ({RS_Pending, RT_Pending} !== 2'b01) begin n_err++;
      $display("FAIL diff_pend: got %b%b expected 01", RS_Pending, RT_Pending); end
    // Reset cycle with a bypassing write: visible now, not stored.
    rst = 1'b1; RegWrite = 1'b1; RD_Address = 5'd7; RDdata = 32'h77;
    Issue_Valid = 1'b1; Issue_Address = 5'd8; RS_Address = 5'd7;
    #1;
    n_cmp++; if (RSdata !== 32'h77) begin n_err++; cmp_d("rst_bypass", RSdata, 32'h77); end
    tick();
    idle();
    RS_Address = 5'd2; RT_Address = 5'd6;
    #1;
    n_cmp++; if (Pending_Count !== 6'd0) begin n_err++;
      $display("FAIL rst_count: got %0d expected 0", Pending_Count); end
    n_cmp++; if (RSdata !== 32'd0) begin n_err++; cmp_d("rst_data2", RSdata, 32'd0); end
    n_cmp++; if (RT_Pending !== 1'b0) begin n_err++;
      $display("FAIL rst_pend6: got %b expected 0", RT_Pending); end
    RS_Address = 5'd7; RT_Address = 5'd8;
    #1;
    n_cmp++; if (RSdata !== 32'd0) begin n_err++; cmp_d("rst_nostore7", RSdata, 32'd0); end
    n_cmp++; if (RT_Pending !== 1'b0) begin n_err++;
      $display("FAIL rst_noissue8: got %b expected 0", RT_Pending); end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    // Half the time use a narrow range to force address collisions.
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, N - 1));
  endfunction

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst           = ($urandom_range(0, 59) == 0);
      RegWrite      = ($urandom_range(0, 2) != 0);
      RD_Address    = rand_addr();
      RDdata        = $urandom;
      Issue_Valid   = ($urandom_range(0, 1) == 1);
      Issue_Address = rand_addr();
      RS_Address    = rand_addr();
      RT_Address    = rand_addr();
      #1;
      n_cmp++; if (RSdata !== exp_data(RS_Address)) begin n_err++;
        $display("FAIL rnd_rsdata c%0d a%0d: got 0x%08h expected 0x%08h", c, RS_Address, RSdata, exp_data(RS_Address)); end
      n_cmp++; if (RTdata !== exp_data(RT_Address)) begin n_err++;
        $display("FAIL rnd_rtdata c%0d a%0d: got 0x%08h expected 0x%08h", c, RT_Address, RTdata, exp_data(RT_Address)); end
      n_cmp++; if (RS_Pending !== exp_pend(RS_Address)) begin n_err++;
        $display("FAIL rnd_rspend c%0d a%0d: got %b expected %b", c, RS_Address, RS_Pending, exp_pend(RS_Address)); end
      n_cmp++; if (RT_Pending !== exp_pend(RT_Address)) begin n_err++;
        $display("FAIL rnd_rtpend c%0d a%0d: got %b expected %b", c, RT_Address, RT_Pending, exp_pend(RT_Address)); end
      n_cmp++; if (int'(Pending_Count) != exp_count()) begin n_err++;
        $display("FAIL rnd_count c%0d: got %0d expected %0d", c, Pending_Count, exp_count()); end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    RegWrite = 1'b0; RD_Address = '0; RDdata = '0;
    Issue_Valid = 1'b0; Issue_Address = '0;
    RS_Address = '0; RT_Address = '0;
    for (int i = 0; i < N; i++) begin
      m_data[i] = '0;
      m_pend[i] = 1'b0;
    end
    #1;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_issue_sequence();
    test_issue_write_same();
    test_diff_then_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Parametrised MIPS register file with write-through bypass, synchronous clear, a hardwired zero register, and an integrated pending-write scoreboard. It replaces the fixed 32x32 register file between decode and writeback. Decode marks destinations as pending at issue, and writeback clears them. Hazard logic reads the per-operand pending flags and an outstanding-write count directly from this block.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W entries
- ZERO_REG, 1, 1 = entry 0 always reads 0, ignores writes and is never pending; 0 = entry 0 is an ordinary register

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- RegWrite  input  1  writeback enable
- RD_Address  input  ADDR_W  writeback destination
- RDdata  input  DATA_W  writeback data
- Issue_Valid  input  1  decode issues an instruction that will write Issue_Address
- Issue_Address  input  ADDR_W  destination to mark pending
- RS_Address  input  ADDR_W  read port A address
- RT_Address  input  ADDR_W  read port B address
- RSdata  output  DATA_W  read port A data (combinational)
- RTdata  output  DATA_W  read port B data (combinational)
- RS_Pending  output  1  port A register has an outstanding write
- RT_Pending  output  1  port B register has an outstanding write
- Pending_Count  output  ADDR_W+1  number of set pending bits

## Operation
- Storage: 2**ADDR_W x DATA_W data array plus a 2**ADDR_W pending-bit vector.
- Reset (rst=1 at edge):
  - All data entries clear to 0.
  - All pending bits and Pending_Count clear to 0.
  - RegWrite and Issue_Valid are ignored in that cycle.
- Write: if RegWrite=1 and the entry is writable, data[RD_Address] takes RDdata at the edge, and pend[RD_Address] clears.
- Issue: if Issue_Valid=1 and the entry is writable, pend[Issue_Address] sets at the edge.
- Issue and write to the same address in the same cycle: set wins, so the bit stays/becomes 1 (newer producer outstanding). Data is still written.
- Writable means: not (ZERO_REG=1 and address==0).
- Read data, per port:
  - 0 if ZERO_REG=1 and address==0.
  - Otherwise RDdata if RegWrite=1 and RD_Address==address (write-through bypass).
  - Otherwise data[address].
- Pending flag, per port:
  - pend[address], except forced 0 when RegWrite=1 and RD_Address==address and the same address is not being issued that cycle.
  - Always 0 for entry 0 when ZERO_REG=1.
- Pending_Count:
  - Registered.
  - Increments by 1 when a bit goes 0→1.
  - Decrements by 1 when a bit goes 1→0.
  - Net change when issue and write hit different addresses.
  - Never exceeds 2**ADDR_W.
- A write to a non-pending register is legal: data updates and the count is unchanged.
- Re-issuing an already pending register: bit stays 1, count unchanged.

## Timing
- Reads are zero-latency combinational from addresses, RegWrite, RD_Address and RDdata. No clock edge is needed to observe a same-cycle write.
- Writes, issue marks, clears and count updates are visible (non-bypassed) from the cycle after the edge.
- Reset values: RSdata = RTdata = 0 for any address after reset until written; RS_Pending = RT_Pending = 0; Pending_Count = 0.
- Reset asserted mid-operation discards all outstanding pending state and data in one cycle. Bypass still applies combinationally during the reset cycle, but nothing is stored.
- No handshake back-pressure: the caller must not issue beyond depth, and the block saturates nothing.

## Test plan
- Reset then read addresses 0, 7 and 31 → RSdata/RTdata = 0, pending flags 0, Pending_Count = 0.
- RegWrite=1, RD=5, RDdata=0x1234 with RS=5 in the same cycle → RSdata=0x1234 immediately; next cycle with RegWrite=0 → still 0x1234.
- Zero register (ZERO_REG=1): write 0xFFFF to entry 0 and issue entry 0 → RSdata=0, RS_Pending=0, Pending_Count unchanged.
- Issue 3, then 9, then 3 again on successive cycles → Pending_Count 1, 2, 2. Then write 9 with RT=9 → RT_Pending=0 in the same cycle; count=1 next cycle.
- Issue 4 and write 4 in the same cycle → data updated, RS_Pending (RS=4) reads 1 next cycle, count increments by 1.
- Issue 6 and write 2 (pending) in the same cycle → count unchanged. Then assert rst with 6 pending → count=0 and data[2]=0 next cycle.
